// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the program loader and the core it feeds:
// lifecycle state encoding, fetch width and the idle instruction value.
package instruction_loader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int INSTR_W    = 8;
  localparam logic [INSTR_W-1:0] FILL_INSTR_DEF = 8'h00;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    RUN     = 2'd3
  } state_t;

endpackage

// File: rtl/instruction_ram.sv
// Single-port instruction store: synchronous write, registered read, no reset
// so the array maps onto block RAM.
module instruction_ram #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
    rd_data <= mem[addr];
  end

endmodule

// File: rtl/instruction_loader.sv
// Streams a program into RAM over a valid/ready port, then serves it to the
// core by read_address with one cycle of latency while in RUN.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int                  ADDR_W     = ADDR_W_DEF,
  parameter int                  DEPTH      = 2 ** ADDR_W,
  parameter int                  DATA_W     = INSTR_W,
  parameter logic [DATA_W-1:0]   FILL_INSTR = FILL_INSTR_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_done,
  input  logic              load_restart,
  input  logic              run_enable,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W:0]   program_length,
  output logic [1:0]        state,
  output logic              overflow
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  DEPTH_L    = LEN_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  state_t            cur_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [LEN_W-1:0]  len_q;
  logic              ovf_q;
  logic              vld_p1;
  logic              loading_phase;
  logic              accept;
  logic              fetch_hit;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata_p1;

  assign loading_phase = (cur_state == EMPTY) || (cur_state == LOADING);
  assign load_ready    = loading_phase && (len_q < DEPTH_L);
  // A restart in the same cycle discards the offered byte as well.
  assign accept        = load_valid && load_ready && !load_restart;
  assign fetch_hit     = (cur_state == RUN) && run_enable && !load_restart
                         && ({1'b0, read_address} < len_q);

  // Loading and fetching never overlap, so one RAM port serves both.
  assign ram_addr = accept ? wr_ptr : read_address;

  instruction_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (accept),
    .addr    (ram_addr),
    .wr_data (load_data),
    .rd_data (ram_rdata_p1)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cur_state <= EMPTY;
      wr_ptr    <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= fetch_hit;
      if (load_restart) begin
        cur_state <= EMPTY;
        wr_ptr    <= '0;
        len_q     <= '0;
        ovf_q     <= 1'b0;
      end else begin
        if (accept) begin
          len_q <= len_q + 1'b1;
          if (wr_ptr != LAST_ADDR) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
        if (loading_phase && load_valid && !load_ready) begin
          ovf_q <= 1'b1;
        end
        case (cur_state)
          EMPTY: begin
            if (load_done) begin
              cur_state <= READY;
            end else if (accept) begin
              cur_state <= LOADING;
            end
          end
          LOADING: if (load_done)   cur_state <= READY;
          READY:   if (run_enable)  cur_state <= RUN;
          RUN:     if (!run_enable) cur_state <= READY;
          default: cur_state <= EMPTY;
        endcase
      end
    end
  end

  // ---- fetch stage p1: registered RAM word, masked unless the lookup hit ----
  assign instruction    = vld_p1 ? ram_rdata_p1 : FILL_INSTR;
  assign program_length = len_q;
  assign state          = cur_state;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: load, fetch, full/overflow,
// restart and asynchronous clear scenarios with hand-computed expectations.
module tb_instruction_loader;

  logic       clock;
  logic       clear;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       load_restart;
  logic       run_enable;
  logic [7:0] read_address;
  logic [7:0] instruction;
  logic [8:0] program_length;
  logic [1:0] state;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  instruction_loader dut (
    .clock          (clock),
    .clear          (clear),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .load_done      (load_done),
    .load_restart   (load_restart),
    .run_enable     (run_enable),
    .read_address   (read_address),
    .instruction    (instruction),
    .program_length (program_length),
    .state          (state),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    clear        = 1'b0;
    load_valid   = 1'b0;
    load_data    = 8'h00;
    load_done    = 1'b0;
    load_restart = 1'b0;
    run_enable   = 1'b0;
    read_address = 8'h00;
    #7;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_len", 32'(program_length), 32'd0);
    chk("rst_instr", 32'(instruction), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);
    #5 clear = 1'b1;

    // Basic three-byte program and fetch
    load_byte(8'h41);
    chk("p1_loading", 32'(state), 32'd1);
    load_byte(8'h82);
    load_byte(8'hC3);
    chk("p1_len", 32'(program_length), 32'd3);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("p1_ready", 32'(state), 32'd2);
    chk("p1_ready_low", 32'(load_ready), 32'd0);
    run_enable = 1'b1;
    tick();
    chk("p1_run", 32'(state), 32'd3);
    chk("p1_first_fill", 32'(instruction), 32'h00);
    read_address = 8'd0; tick(); chk("p1_fetch0", 32'(instruction), 32'h41);
    read_address = 8'd1; tick(); chk("p1_fetch1", 32'(instruction), 32'h82);
    read_address = 8'd2; tick(); chk("p1_fetch2", 32'(instruction), 32'hC3);
    read_address = 8'd3; tick(); chk("p1_fetch3_beyond", 32'(instruction), 32'h00);

    // Drop run_enable while pointing at valid data, then restart
    read_address = 8'd1;
    run_enable   = 1'b0;
    tick();
    chk("stop_state", 32'(state), 32'd2);
    chk("stop_instr", 32'(instruction), 32'h00);
    load_restart = 1'b1;
    tick();
    load_restart = 1'b0;
    chk("rs_state", 32'(state), 32'd0);
    chk("rs_len", 32'(program_length), 32'd0);
    chk("rs_ready", 32'(load_ready), 32'd1);

    // Final byte together with load_done
    load_byte(8'h11);
    load_byte(8'h22);
    load_byte(8'h33);
    load_valid = 1'b1;
    load_data  = 8'h55;
    load_done  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    chk("fd_len", 32'(program_length), 32'd4);
    chk("fd_state", 32'(state), 32'd2);
    load_valid = 1'b1;
    load_data  = 8'hEE;
    tick();
    load_valid = 1'b0;
    chk("ready_ignores_len", 32'(program_length), 32'd4);
    chk("ready_no_ovf", 32'(overflow), 32'd0);
    run_enable = 1'b1;
    tick();
    read_address = 8'd3; tick(); chk("fd_fetch3", 32'(instruction), 32'h55);
    read_address = 8'd0; tick(); chk("fd_fetch0", 32'(instruction), 32'h11);
    read_address = 8'd4; tick(); chk("fd_fetch4_beyond", 32'(instruction), 32'h00);
    run_enable   = 1'b0;
    load_restart = 1'b1;
    tick();
    load_restart = 1'b0;
    chk("rs2_state", 32'(state), 32'd0);

    // Fill all 256 entries, then offer one more byte
    for (int i = 0; i < 256; i++) begin
      load_byte(8'(i));
    end
    chk("full_len", 32'(program_length), 32'd256);
    chk("full_ready", 32'(load_ready), 32'd0);
    chk("full_no_ovf_yet", 32'(overflow), 32'd0);
    load_byte(8'hAA);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_len", 32'(program_length), 32'd256);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("full_ready_state", 32'(state), 32'd2);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    run_enable = 1'b1;
    tick();
    read_address = 8'd255; tick(); chk("full_fetch255", 32'(instruction), 32'hFF);
    read_address = 8'd0;   tick(); chk("full_fetch0", 32'(instruction), 32'h00);
    read_address = 8'd128; tick(); chk("full_fetch128", 32'(instruction), 32'h80);
    read_address = 8'd7;   tick(); chk("full_fetch7", 32'(instruction), 32'h07);
    load_restart = 1'b1;
    tick();
    load_restart = 1'b0;
    run_enable   = 1'b0;
    chk("rs3_state", 32'(state), 32'd0);
    chk("rs3_ovf", 32'(overflow), 32'd0);
    chk("rs3_instr", 32'(instruction), 32'h00);

    // Asynchronous clear in the middle of loading
    load_byte(8'h01);
    load_byte(8'h02);
    chk("ac_len_before", 32'(program_length), 32'd2);
    chk("ac_loading", 32'(state), 32'd1);
    #2 clear = 1'b0;
    #1;
    chk("ac_state", 32'(state), 32'd0);
    chk("ac_len", 32'(program_length), 32'd0);
    chk("ac_ready", 32'(load_ready), 32'd1);
    clear = 1'b1;
    tick();
    chk("ac_after_state", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Program-side counterpart of the single-cycle core: serves 8-bit instructions against the core's `read_address` output.
- Before execution, the program is streamed in byte-by-byte over a valid/ready load port.
- Holds the program in an internal RAM and tracks the program length.
- Sequences the EMPTY -> LOADING -> READY -> RUN lifecycle. Runs on the same divided clock as the core.

Parameters:
- ADDR_W, 8, width of `read_address` and of the write pointer.
- DEPTH, 256, instruction RAM entries (must equal 2**ADDR_W).
- FILL_INSTR, 8'h00, value driven on `instruction` outside RUN or beyond program end.

Ports:
- clock  in  1  system clock (same divided clock as the core), rising edge
- clear  in  1  reset, asynchronous, active-low
- load_valid  in  1  load_data holds a program byte
- load_data  in  8  program byte
- load_ready  out  1  block accepts a byte this cycle
- load_done  in  1  end-of-program strobe
- load_restart  in  1  discard program, return to EMPTY
- run_enable  in  1  level; high = core may execute
- read_address  in  ADDR_W  fetch address from core
- instruction  out  8  registered instruction to core
- program_length  out  ADDR_W+1  number of stored bytes (0..DEPTH)
- state  out  2  EMPTY=0, LOADING=1, READY=2, RUN=3
- overflow  out  1  sticky: byte offered while RAM full

Behaviour:
- Reset (clear=0, async):
  - state=EMPTY, wr_ptr=0, program_length=0.
  - instruction=FILL_INSTR, overflow=0, load_ready=1.
  - RAM contents are not reset.
- Handshake: a byte is accepted when load_valid && load_ready at a rising edge. It is written to RAM[wr_ptr]; wr_ptr and program_length increment.
- load_ready = (state==EMPTY || state==LOADING) && program_length<DEPTH.
- EMPTY:
  - Accepted byte -> LOADING.
  - load_done with no byte -> READY, length 0.
- LOADING:
  - load_done -> READY.
  - If load_valid, load_ready and load_done are all high in the same cycle: the byte is written first, then READY; length includes that byte.
- Full: when program_length==DEPTH, load_ready=0.
  - load_valid while full sets overflow (sticky until clear or load_restart).
  - The byte is dropped; wr_ptr does not wrap.
- READY:
  - run_enable=1 -> RUN.
  - Bytes are not accepted; load_valid is ignored and does not set overflow.
- RUN:
  - Each edge: instruction <= (read_address < program_length) ? RAM[read_address] : FILL_INSTR.
  - Latency is 1 cycle from read_address to instruction.
  - run_enable=0 -> READY; instruction is forced to FILL_INSTR on that edge.
- Outside RUN, instruction=FILL_INSTR.
- load_restart (any state except EMPTY) -> EMPTY: wr_ptr=0, length=0, overflow=0, instruction=FILL_INSTR.
- Priority: load_restart > load_done > run_enable.
- clear asserted mid-load or mid-run aborts immediately to the reset values above. The program must be reloaded.
- Widths: program_length is ADDR_W+1 bits so DEPTH itself is representable. The comparison is unsigned.

Decomposition:
- Shared package:
  - state encoding constants EMPTY/LOADING/READY/RUN.
  - FILL_INSTR default.
  - ADDR_W default (shared with the core's read_address width).
- One sub-module: `instruction_ram`, a single-port synchronous-read RAM. Write when accepted; read registered; no reset.
- FSM, pointer, handshake and fetch mux stay in the top.

Test Plan:
- Reset -> state=0, load_ready=1, program_length=0, instruction=8'h00, overflow=0.
- Load 8'h41, 8'h82, 8'hC3 then load_done, run_enable=1; read_address 0,1,2,3 on successive cycles -> instruction 8'h41, 8'h82, 8'hC3, 8'h00 each one cycle later.
- Final byte 8'h55 with load_valid and load_done in the same cycle -> program_length=4, state=READY, fetch at address 3 returns 8'h55.
- Load 256 bytes (value = index), then one more load_valid -> load_ready=0 after 256th byte, overflow=1, program_length=256, RAM[255]=8'hFF intact.
- In RUN, drop run_enable -> state=READY, instruction=8'h00 next edge. Then load_restart -> state=EMPTY, program_length=0, load_ready=1.
- Pulse clear low mid-LOADING after 2 bytes (asynchronous, between edges) -> state=EMPTY, program_length=0 immediately, without waiting for a clock edge.
